// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735R command decoder: opcodes, FSM states, panel defaults.
package st7735_pkg;

    localparam int unsigned DEF_H_RES = 480;
    localparam int unsigned DEF_V_RES = 272;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_SKIP
    } dec_state_t;

endpackage

// File: rtl/st7735_cmd_decoder_if.sv
// Byte-stream input and frame-buffer write output of the command decoder.
interface st7735_cmd_decoder_if #(
    parameter int unsigned AW = 17
) ();

    logic [7:0]    i_data;
    logic          i_dc;
    logic          i_rxdone;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [15:0]   o_wr_data;
    logic          o_ramwr;

    modport master (
        output i_data, i_dc, i_rxdone,
        input  o_wr_en, o_wr_addr, o_wr_data, o_ramwr
    );

    modport slave (
        input  i_data, i_dc, i_rxdone,
        output o_wr_en, o_wr_addr, o_wr_data, o_ramwr
    );

endinterface

// File: rtl/st7735_addr_gen.sv
// Pixel cursor for the active window: walks x then y, wrapping to the top-left corner.
module st7735_addr_gen
    import st7735_pkg::*;
#(
    parameter int unsigned H_RES = DEF_H_RES,
    parameter int unsigned AW    = 17
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          load,
    input  logic [8:0]    xs,
    input  logic [8:0]    ys,
    input  logic [8:0]    xe,
    input  logic [8:0]    ye,
    input  logic          step,
    output logic [AW-1:0] addr
);

    logic [8:0]    cx, cy;
    logic [8:0]    xs_q, ys_q, xe_q, ye_q;
    logic [AW-1:0] rowbase, ys_base;
    logic [AW-1:0] load_base;

    // Row base of the start row; needed at entry and again whenever the window wraps.
    always_comb begin
        load_base = AW'(ys) * AW'(H_RES);
    end

    // Cursor register: load at RAMWR entry, advance one pixel per completed write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cx      <= '0;
            cy      <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            rowbase <= '0;
            ys_base <= '0;
        end else if (load) begin
            cx      <= xs;
            cy      <= ys;
            xs_q    <= xs;
            ys_q    <= ys;
            xe_q    <= xe;
            ye_q    <= ye;
            rowbase <= load_base;
            ys_base <= load_base;
        end else if (step) begin
            if (cx < xe_q) begin
                cx <= cx + 9'd1;
            end else begin
                cx <= xs_q;
                if (cy < ye_q) begin
                    cy      <= cy + 9'd1;
                    rowbase <= rowbase + AW'(H_RES);
                end else begin
                    cy      <= ys_q;
                    rowbase <= ys_base;
                end
            end
        end
    end

    assign addr = rowbase + AW'(cx);

endmodule

// File: rtl/st7735_cmd_decoder.sv
// ST7735R command subset decoder (CASET/RASET/RAMWR/SWRESET) feeding an RGB565 frame buffer.
module st7735_cmd_decoder
    import st7735_pkg::*;
#(
    parameter int unsigned H_RES = DEF_H_RES,
    parameter int unsigned V_RES = DEF_V_RES,
    parameter int unsigned AW    = 17
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    st7735_cmd_decoder_if.slave  bus
);

    dec_state_t    state_q, state_d;
    logic [1:0]    idx_q;
    logic [23:0]   tmp_q;
    logic [7:0]    hi_q;
    logic          half_q;
    logic [15:0]   xs_q, xe_q, ys_q, ye_q;
    logic          empty_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [15:0]   wr_data_q;

    logic          is_cmd, is_dat, ramwr_entry, pix_done, win_empty;
    logic [8:0]    xe_eff, ye_eff;
    logic [AW-1:0] gen_addr;

    // Strobe qualification, window clamping and pixel-completion detect.
    always_comb begin
        is_cmd      = bus.i_rxdone & ~bus.i_dc;
        is_dat      = bus.i_rxdone & bus.i_dc;
        ramwr_entry = is_cmd && (bus.i_data == CMD_RAMWR);
        xe_eff      = (xe_q > 16'(H_RES - 1)) ? 9'(H_RES - 1) : xe_q[8:0];
        ye_eff      = (ye_q > 16'(V_RES - 1)) ? 9'(V_RES - 1) : ye_q[8:0];
        win_empty   = (xs_q > {7'd0, xe_eff}) || (ys_q > {7'd0, ye_eff});
        pix_done    = is_dat && (state_q == ST_RAMWR) && half_q && !empty_q;
    end

    st7735_addr_gen #(
        .H_RES (H_RES),
        .AW    (AW)
    ) u_addr_gen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .load  (ramwr_entry),
        .xs    (xs_q[8:0]),
        .ys    (ys_q[8:0]),
        .xe    (xe_eff),
        .ye    (ye_eff),
        .step  (pix_done),
        .addr  (gen_addr)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: commands always re-decode; data only finishes CASET/RASET.
    always_comb begin
        state_d = state_q;
        if (is_cmd) begin
            case (bus.i_data)
                CMD_CASET:   state_d = ST_CASET;
                CMD_RASET:   state_d = ST_RASET;
                CMD_RAMWR:   state_d = ST_RAMWR;
                CMD_SWRESET: state_d = ST_IDLE;
                CMD_NOP:     state_d = ST_IDLE;
                default:     state_d = ST_SKIP;
            endcase
        end else if (is_dat) begin
            if ((state_q == ST_CASET || state_q == ST_RASET) && idx_q == 2'd3) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Outputs: registered write port, o_ramwr straight from the state.
    always_comb begin
        bus.o_wr_en   = wr_en_q;
        bus.o_wr_addr = wr_addr_q;
        bus.o_wr_data = wr_data_q;
        bus.o_ramwr   = (state_q == ST_RAMWR);
    end

    // Parameter collection, window registers and pixel assembly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q     <= '0;
            tmp_q     <= '0;
            hi_q      <= '0;
            half_q    <= 1'b0;
            xs_q      <= '0;
            xe_q      <= 16'(H_RES - 1);
            ys_q      <= '0;
            ye_q      <= 16'(V_RES - 1);
            empty_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (is_cmd) begin
                idx_q  <= '0;
                half_q <= 1'b0;
                if (bus.i_data == CMD_SWRESET) begin
                    xs_q <= '0;
                    xe_q <= 16'(H_RES - 1);
                    ys_q <= '0;
                    ye_q <= 16'(V_RES - 1);
                end
                if (ramwr_entry) begin
                    empty_q <= win_empty;
                end
            end else if (is_dat) begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        // First three bytes shift into tmp; the fourth commits S and E together.
                        if (idx_q == 2'd3) begin
                            idx_q <= '0;
                            if (state_q == ST_CASET) begin
                                xs_q <= tmp_q[23:8];
                                xe_q <= {tmp_q[7:0], bus.i_data};
                            end else begin
                                ys_q <= tmp_q[23:8];
                                ye_q <= {tmp_q[7:0], bus.i_data};
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                            tmp_q <= {tmp_q[15:0], bus.i_data};
                        end
                    end
                    ST_RAMWR: begin
                        if (!half_q) begin
                            hi_q   <= bus.i_data;
                            half_q <= 1'b1;
                        end else begin
                            half_q <= 1'b0;
                            if (!empty_q) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= gen_addr;
                                wr_data_q <= {hi_q, bus.i_data};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_st7735_cmd_decoder.sv
// Directed, table-driven bench for st7735_cmd_decoder.
module tb_st7735_cmd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    st7735_cmd_decoder_if #(.AW(17)) bus ();

    st7735_cmd_decoder #(
        .H_RES (480),
        .V_RES (272),
        .AW    (17)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic       wr;
        int         addr;
        int         dat;
        logic       ramwr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One byte strobe, spaced >=8 cycles from the previous; returns #1 after the strobe edge.
    task automatic send(input logic dc, input logic [7:0] b);
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus.i_dc     = dc;
        bus.i_data   = b;
        bus.i_rxdone = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rxdone = 1'b0;
    endtask

    task automatic pix(input logic [7:0] hi, input logic [7:0] lo,
                       input logic exp_wr, input int exp_addr, input string nm);
        send(1'b1, hi);
        chk({nm, "_hi_wr"}, int'(bus.o_wr_en), 0);
        send(1'b1, lo);
        chk({nm, "_wr"}, int'(bus.o_wr_en), int'(exp_wr));
        if (exp_wr) begin
            chk({nm, "_addr"}, int'(bus.o_wr_addr), exp_addr);
            chk({nm, "_data"}, int'(bus.o_wr_data), int'({hi, lo}));
        end
    endtask

    task automatic cmd4(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [7:0] e);
        send(1'b0, c);
        send(1'b1, a);
        send(1'b1, b);
        send(1'b1, d);
        send(1'b1, e);
    endtask

    initial begin
        bus.i_data   = '0;
        bus.i_dc     = 1'b0;
        bus.i_rxdone = 1'b0;

        // dc, byte, wr, addr, data, ramwr
        vecs.push_back('{1'b0, 8'h2C, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'hF8, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 0, 16'hF800, 1'b1});
        vecs.push_back('{1'b0, 8'h2A, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h0A, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h0B, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b0, 8'h2B, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h05, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h06, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b0, 8'h2C, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h11, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h22, 1'b1, 2410, 16'h1122, 1'b1});
        vecs.push_back('{1'b1, 8'h33, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h44, 1'b1, 2411, 16'h3344, 1'b1});
        vecs.push_back('{1'b1, 8'h55, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h66, 1'b1, 2890, 16'h5566, 1'b1});
        vecs.push_back('{1'b1, 8'h77, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h88, 1'b1, 2891, 16'h7788, 1'b1});
        vecs.push_back('{1'b1, 8'h99, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'hAA, 1'b1, 2410, 16'h99AA, 1'b1});
        vecs.push_back('{1'b0, 8'h2C, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b1, 8'h12, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h34, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b0, 8'h55, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h2C, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h01, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{1'b0, 8'h01, 1'b0, 0, 0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", int'(bus.o_wr_en), 0);
        chk("rst_addr", int'(bus.o_wr_addr), 0);
        chk("rst_data", int'(bus.o_wr_data), 0);
        chk("rst_ramwr", int'(bus.o_ramwr), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].dc, vecs[i].b);
            chk($sformatf("vec%0d_wr", i), int'(bus.o_wr_en), int'(vecs[i].wr));
            chk($sformatf("vec%0d_ramwr", i), int'(bus.o_ramwr), int'(vecs[i].ramwr));
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_addr", i), int'(bus.o_wr_addr), vecs[i].addr);
                chk($sformatf("vec%0d_data", i), int'(bus.o_wr_data), vecs[i].dat);
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d_pulse_end", i), int'(bus.o_wr_en), 0);
                chk($sformatf("vec%0d_addr_hold", i), int'(bus.o_wr_addr), vecs[i].addr);
            end
        end

        // XE=500 clamps to 479; the 480th pixel lands at the start of row 1.
        cmd4(8'h2A, 8'h00, 8'h01, 8'h01, 8'hF4);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 480; i++) begin
            pix(8'(i >> 8), 8'(i), 1'b1, (i < 479) ? i + 1 : 481, $sformatf("clamp%0d", i));
        end

        // XS > XE: bytes consumed, no writes.
        cmd4(8'h2A, 8'h00, 8'h05, 8'h00, 8'h02);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 4; i++) begin
            pix(8'hC0, 8'(i), 1'b0, 0, $sformatf("empty%0d", i));
        end
        chk("empty_ramwr", int'(bus.o_ramwr), 1);

        // XS beyond the panel width is also empty.
        cmd4(8'h2A, 8'h01, 8'hE0, 8'h01, 8'hF4);
        send(1'b0, 8'h2C);
        pix(8'hC1, 8'h01, 1'b0, 0, "xs480");

        // Partial CASET leaves the full-screen window from SWRESET intact.
        send(1'b0, 8'h01);
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00);
        send(1'b1, 8'h05);
        send(1'b0, 8'h2C);
        pix(8'hAB, 8'hCD, 1'b1, 0, "partial");

        // Reset mid-pixel with a non-default window in place.
        cmd4(8'h2A, 8'h00, 8'h03, 8'h00, 8'h09);
        cmd4(8'h2B, 8'h00, 8'h02, 8'h00, 8'h04);
        send(1'b0, 8'h2C);
        pix(8'h01, 8'h02, 1'b1, 963, "prerst");
        send(1'b1, 8'hEE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ramwr", int'(bus.o_ramwr), 0);
        chk("midrst_addr", int'(bus.o_wr_addr), 0);
        chk("midrst_data", int'(bus.o_wr_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pix(8'hAB, 8'hCD, 1'b0, 0, "postrst_nowr");
        chk("postrst_ramwr", int'(bus.o_ramwr), 0);
        send(1'b0, 8'h2C);
        pix(8'h5A, 8'hA5, 1'b1, 0, "postrst_full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
